microwave_timer: RTL
====================

MICROWAVE_TIMER -- requirements
Module: microwave_timer

Interface
REQ-001 Parameter BEEP_TICKS, default 3, number of tick strobes beep stays high after expiry.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  one-cycle 1 Hz enable strobe from upstream prescaler/counter.
REQ-005 load  input  1  one-cycle strobe; captures preset time.
REQ-006 min_in  input  4  preset minutes, BCD 0-9.
REQ-007 sec_tens_in  input  3  preset seconds tens, BCD 0-5.
REQ-008 sec_ones_in  input  4  preset seconds ones, BCD 0-9.
REQ-009 start  input  1  one-cycle strobe; begin or resume countdown.
REQ-010 stop  input  1  one-cycle strobe; pause, or clear when paused/done.
REQ-011 door_open  input  1  level; door sensor, high = open.
REQ-012 min, sec_tens, sec_ones  output  4/3/4  current remaining time, BCD.
REQ-013 running  output  1  high while state RUN (magnetron enable).
REQ-014 done  output  1  one-cycle pulse on reaching 00:00.
REQ-015 beep  output  1  buzzer enable (see Configuration).

Function
REQ-016 FSM states IDLE, RUN, PAUSE, DONE; registered outputs only.
REQ-017 IDLE: load captures preset; start with time != 00:00 and door_open=0 -> RUN; otherwise start ignored.
REQ-018 Load clamps: sec_tens_in>5 -> 5, sec_ones_in>9 -> 9, min_in>9 -> 9.
REQ-019 Load accepted only in IDLE and PAUSE; ignored in RUN and DONE.
REQ-020 RUN: on tick, time decrements by one second with BCD borrow (x:00 -> (x-1):59); update visible cycle after tick.
REQ-021 RUN: tick while time = 00:01 -> time 00:00, state DONE, done=1 for exactly the following cycle.
REQ-022 RUN: stop or door_open=1 -> PAUSE; same-cycle tick is discarded (no decrement).
REQ-023 PAUSE: start with door_open=0 -> RUN, time preserved; stop -> IDLE with time 00:00.
REQ-024 DONE: stop or load -> IDLE with time 00:00 (load value not captured); start ignored.
REQ-025 Simultaneous strobes priority: stop > load > start.
REQ-026 Time never underflows below 00:00; ticks outside RUN have no effect on time.

Reset
REQ-027 clr=1 asynchronously forces IDLE, time 00:00, running=0, done=0, beep=0, beep counter 0, including mid-countdown.
REQ-028 Outputs stay at reset values until first clock edge after clr deasserts.

Configuration
REQ-029 Macro MICROWAVE_BEEP_EN defined: beep rises with done, stays high for BEEP_TICKS tick strobes, then falls; stop or load in DONE clears it immediately.
REQ-030 Macro MICROWAVE_BEEP_EN undefined: beep tied 0, beep counter not built; all other behaviour unchanged.

Structure
REQ-031 Shared package microwave_pkg holds FSM state encoding, BCD digit widths, and max-digit constants (5, 9).
REQ-032 Sub-module bcd_digit_down: one BCD digit, decrement enable, wrap value input, borrow out; instantiated three times and chained.

Verification
REQ-033 load 1:30, start, 3 ticks -> 1:27, running=1 throughout.
REQ-034 load 0:02, start, 2 ticks -> 0:00, done pulse 1 cycle, running=0, state DONE; extra ticks leave 0:00.
REQ-035 load 1:00, start, 1 tick -> 0:59 (borrow across digits).
REQ-036 RUN at 0:45, door_open=1 with tick same cycle -> PAUSE at 0:45; start while open ignored; close, start -> RUN resumes from 0:45.
REQ-037 load sec_tens_in=7 sec_ones_in=12 -> 0:59 stored; clr mid-RUN -> 0:00, IDLE immediately, without clock edge.
REQ-038 With MICROWAVE_BEEP_EN, BEEP_TICKS=3: expiry -> beep high for exactly 3 ticks; without macro -> beep stays 0.

Source files
------------

// File: rtl/microwave_pkg.sv
// -----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave countdown timer.
// The package has no ports. It provides:
//   state_e       FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   *_W           BCD digit widths for minutes, seconds-tens and seconds-ones
//   MAX_*         largest legal value of each digit (9 / 5 / 9)
//   bcd_time_t    the mm:ss value held as three BCD digits
//   clamp_preset  saturates an out-of-range preset to the legal maximum
// -----------------------------------------------------------------------------
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned MIN_W  = 4;
  localparam int unsigned TENS_W = 3;
  localparam int unsigned ONES_W = 4;

  localparam logic [MIN_W-1:0]  MAX_MIN      = 4'd9;
  localparam logic [TENS_W-1:0] MAX_SEC_TENS = 3'd5;
  localparam logic [ONES_W-1:0] MAX_SEC_ONES = 4'd9;

  typedef struct packed {
    logic [MIN_W-1:0]  mins;
    logic [TENS_W-1:0] tens;
    logic [ONES_W-1:0] ones;
  } bcd_time_t;

  // Each digit saturates on its own; an illegal seconds-tens of 7 becomes 5.
  function automatic bcd_time_t clamp_preset(input logic [MIN_W-1:0]  m,
                                             input logic [TENS_W-1:0] t,
                                             input logic [ONES_W-1:0] o);
    bcd_time_t r;
    r.mins = (m > MAX_MIN)      ? MAX_MIN      : m;
    r.tens = (t > MAX_SEC_TENS) ? MAX_SEC_TENS : t;
    r.ones = (o > MAX_SEC_ONES) ? MAX_SEC_ONES : o;
    return r;
  endfunction

endpackage : microwave_pkg

// File: rtl/microwave_timer_bcd_digit_down.sv
// -----------------------------------------------------------------------------
// bcd_digit_down
// Combinational decrement of a single BCD digit.
// Ports:
//   digit_i   current digit value
//   dec_i     decrement request (borrow from the less significant digit)
//   wrap_i    value loaded when decrementing from zero (9 or 5)
//   digit_o   next digit value
//   borrow_o  high when the digit wraps, i.e. a borrow into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_down #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] digit_i,
  input  logic         dec_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] digit_o,
  output logic         borrow_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (dec_i) begin
      if (digit_i == '0) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - W'(1);
      end
    end
  end

endmodule : bcd_digit_down

// File: rtl/microwave_timer.sv
// -----------------------------------------------------------------------------
// microwave_timer
// mm:ss countdown timer for a microwave oven, BCD throughout.
// Optional feature: define MICROWAVE_BEEP_EN to build the expiry buzzer;
// without it beep is tied low and the buzzer counter does not exist.
// Ports:
//   clk                        system clock, rising edge
//   clr                        asynchronous active-high reset
//   tick                       1 Hz one-cycle enable strobe
//   load / start / stop        one-cycle command strobes (stop > load > start)
//   door_open                  door sensor level, high = open
//   min_in/sec_tens_in/sec_ones_in  preset time, BCD (clamped on load)
//   min/sec_tens/sec_ones      remaining time, BCD
//   running                    high while counting down (magnetron enable)
//   done                       one-cycle pulse on reaching 00:00
//   beep                       buzzer enable
// -----------------------------------------------------------------------------
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              tick,
  input  logic              load,
  input  logic [MIN_W-1:0]  min_in,
  input  logic [TENS_W-1:0] sec_tens_in,
  input  logic [ONES_W-1:0] sec_ones_in,
  input  logic              start,
  input  logic              stop,
  input  logic              door_open,
  output logic [MIN_W-1:0]  min,
  output logic [TENS_W-1:0] sec_tens,
  output logic [ONES_W-1:0] sec_ones,
  output logic              running,
  output logic              done,
  output logic              beep
);

  if (BEEP_TICKS < 1) begin : g_bad_beep_ticks
    $error("microwave_timer: BEEP_TICKS must be at least 1");
  end

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic      running_q, running_d;
  logic      done_q, done_d;

  logic [MIN_W-1:0]  dec_mins;
  logic [TENS_W-1:0] dec_tens;
  logic [ONES_W-1:0] dec_ones;
  logic              ones_borrow, tens_borrow, min_borrow;
  logic              dec_en, time_zero;
  bcd_time_t         preset, dec_time;

  assign dec_en    = (state_q == ST_RUN) && tick;
  assign time_zero = (time_q == '0);
  assign preset    = clamp_preset(min_in, sec_tens_in, sec_ones_in);
  assign dec_time  = '{mins: dec_mins, tens: dec_tens, ones: dec_ones};

  bcd_digit_down #(.W(ONES_W)) u_ones (
    .digit_i (time_q.ones),  .dec_i   (dec_en),      .wrap_i (MAX_SEC_ONES),
    .digit_o (dec_ones),     .borrow_o(ones_borrow)
  );
  bcd_digit_down #(.W(TENS_W)) u_tens (
    .digit_i (time_q.tens),  .dec_i   (ones_borrow), .wrap_i (MAX_SEC_TENS),
    .digit_o (dec_tens),     .borrow_o(tens_borrow)
  );
  // A borrow out of the minutes digit means the time was already 00:00;
  // the decrement is then suppressed so the time can never underflow.
  bcd_digit_down #(.W(MIN_W)) u_mins (
    .digit_i (time_q.mins),  .dec_i   (tens_borrow), .wrap_i (MAX_MIN),
    .digit_o (dec_mins),     .borrow_o(min_borrow)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!stop && load) begin
          time_d = preset;
        end else if (!stop && start && !time_zero && !door_open) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Pausing wins over a same-cycle tick; that tick is dropped.
        if (stop || door_open) begin
          state_d = ST_PAUSE;
        end else if (tick && !min_borrow) begin
          time_d = dec_time;
          if (dec_time == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (load) begin
          time_d = preset;
        end else if (start && !door_open && !time_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop || load) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min      = time_q.mins;
  assign sec_tens = time_q.tens;
  assign sec_ones = time_q.ones;
  assign running  = running_q;
  assign done     = done_q;

`ifdef MICROWAVE_BEEP_EN
  localparam int unsigned CNT_W = $clog2(BEEP_TICKS + 1);

  logic             beep_q, beep_d;
  logic [CNT_W-1:0] beep_cnt_q, beep_cnt_d;

  // beep can only be high in DONE: it rises on entry and is cleared on exit.
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (done_d) begin
      beep_d     = 1'b1;
      beep_cnt_d = '0;
    end else if ((state_q == ST_DONE) && (stop || load)) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (beep_q && tick) begin
      if (beep_cnt_q == CNT_W'(BEEP_TICKS - 1)) begin
        beep_d     = 1'b0;
        beep_cnt_d = '0;
      end else begin
        beep_cnt_d = beep_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule : microwave_timer
